// File: rtl/ram_responder_pkg.sv
// Shared constants for the bridge's RAM socket.
// Holds the responder state encoding, the default RAM window base and the
// bit positions of the 16-bit ram_ctrl bundle that the bridge packs onto
// the responder's req/we/ack/err/be pins.
package ram_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_WAIT  = 2'd1,
        RSP_RESP  = 2'd2,
        RSP_DRAIN = 2'd3
    } rsp_state_t;

    localparam logic [31:0] RAM_BASE_ADDR = 32'h0020_0000;

    // ram_ctrl bundle layout (16 bits, upper bits reserved)
    localparam int unsigned RAM_CTRL_W = 16;
    localparam int unsigned REQ        = 0;
    localparam int unsigned WE         = 1;
    localparam int unsigned ACK        = 2;
    localparam int unsigned ERR        = 3;
    localparam int unsigned BE_LSB     = 4;   // BE[0]
    localparam int unsigned BE_MSB     = 7;   // BE[3]

endpackage

// File: rtl/ram_word_array.sv
// Synchronous single-port DEPTH x 32 word memory with per-byte write enables.
// Ports:
//   clk   - clock, rising edge
//   en    - access enable for this cycle
//   we    - 1 = write enabled byte lanes, 0 = read into rdata
//   be    - byte lane enables for writes (bit i -> wdata[8*i+7:8*i])
//   idx   - word index
//   wdata - write data
//   rdata - registered read data; only updated by enabled reads
// Contents are not reset.
module ram_word_array
    import ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the bridge's RAM socket.
// Services word reads/writes in the window [BASE_ADDR, BASE_ADDR+DEPTH*4)
// after WAIT_STATES wait cycles, using a four-phase req/ack handshake.
// Out-of-window or misaligned accesses complete with ram_err=1, rdata=0.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   ram_req    - request, held high until ram_ack is seen
//   ram_we     - 1 = write, 0 = read
//   ram_be     - byte enables for writes
//   ram_addr   - byte address
//   ram_wdata  - write data
//   ram_rdata  - read data, valid while ram_ack is high
//   ram_ack    - one-cycle completion pulse
//   ram_err    - qualifies ram_ack: access rejected
//   ram_busy   - high whenever the responder is not idle
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RAM_BASE_ADDR,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_req,
    input  logic        ram_we,
    input  logic [3:0]  ram_be,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_rdata,
    output logic        ram_ack,
    output logic        ram_err,
    output logic        ram_busy
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [32:0] SPAN    = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

    rsp_state_t  state;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic        rd_valid;

    logic [31:0]   off;
    logic          hit;
    logic          access;
    logic [AW-1:0] word_idx;
    logic [31:0]   arr_rdata;

    // Decode works on the latched address only; the bus is ignored after IDLE.
    assign off      = addr_q - BASE_ADDR;
    assign hit      = ({1'b0, off} < SPAN) && (addr_q[1:0] == 2'b00);
    assign word_idx = off[AW+1:2];
    assign access   = (state == RSP_WAIT) && (wait_cnt == '0);

    ram_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (access && hit),
        .we    (we_q),
        .be    (be_q),
        .idx   (word_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // The array read register has no reset, so a registered qualifier forces
    // ram_rdata to zero after reset and after an error; writes leave it alone
    // so the last read value is held.
    assign ram_rdata = rd_valid ? arr_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RSP_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            rd_valid <= 1'b0;
            ram_ack  <= 1'b0;
            ram_err  <= 1'b0;
            ram_busy <= 1'b0;
        end else begin
            case (state)
                RSP_IDLE: begin
                    if (ram_req) begin
                        addr_q   <= ram_addr;
                        wdata_q  <= ram_wdata;
                        we_q     <= ram_we;
                        be_q     <= ram_be;
                        wait_cnt <= WS_INIT;
                        ram_busy <= 1'b1;
                        state    <= RSP_WAIT;
                    end
                end
                RSP_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        ram_ack <= 1'b1;
                        ram_err <= !hit;
                        if (!hit) begin
                            rd_valid <= 1'b0;
                        end else if (!we_q) begin
                            rd_valid <= 1'b1;
                        end
                        state <= RSP_RESP;
                    end
                end
                RSP_RESP: begin
                    ram_ack <= 1'b0;
                    ram_err <= 1'b0;
                    state   <= RSP_DRAIN;
                end
                RSP_DRAIN: begin
                    if (!ram_req) begin
                        ram_busy <= 1'b0;
                        state    <= RSP_IDLE;
                    end
                end
                default: begin
                    state <= RSP_IDLE;
                end
            endcase
        end
    end

endmodule
